// File: rtl/cd_global_xbar_nxm_pkg.sv
// Shared constants for the CD-mesh global crossbar: header field positions,
// statistics counter width and an index-width helper.
package cd_global_xbar_nxm_pkg;

  localparam int HX_LSB   = 52;
  localparam int SRCX_LSB = 40;
  localparam int SRCY_LSB = 32;
  localparam int STAT_W   = 16;

  // Width of an index into n items; never zero so single-entry vectors stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cd_global_xbar_nxm_rr_arb_n.sv
// N-way round-robin arbiter with a registered priority pointer; grants are
// one-hot and combinational, the pointer moves to winner+1 only on a grant.
module rr_arb_n
  import cd_global_xbar_nxm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = idx_w(N);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] idx;
  logic          found;

  // N is a power of two, so index arithmetic wraps naturally at PW bits.
  always_comb begin
    gnt      = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = ptr_reg;
    for (int i = 0; i < N; i++) begin
      idx = ptr_reg + PW'(i);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        ptr_next = idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/cd_global_xbar_nxm.sv
// Registered N_IN x N_LLC global crossbar: round-robin request path to LLC slices
// and reply path back to locals. Optional per-slice counters via CD_XBAR_STATS_EN.
module cd_global_xbar_nxm
  import cd_global_xbar_nxm_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int N_IN   = 8,
  parameter int N_LLC  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_IN-1:0]         in_si,
  output logic [N_IN-1:0]         in_ri,
  input  logic [N_IN*DATA_W-1:0]  in_di,
  output logic [N_LLC-1:0]        llc_so,
  input  logic [N_LLC-1:0]        llc_ro,
  output logic [N_LLC*DATA_W-1:0] llc_do,
  input  logic [N_LLC-1:0]        llc_si_r,
  output logic [N_LLC-1:0]        llc_ri_r,
  input  logic [N_LLC*DATA_W-1:0] llc_di_r,
  output logic [N_IN-1:0]         out_so,
  input  logic [N_IN-1:0]         out_ro,
  output logic [N_IN*DATA_W-1:0]  out_do
`ifdef CD_XBAR_STATS_EN
  ,
  output logic [N_LLC*STAT_W-1:0] llc_req_cnt
`endif
);

  localparam int LLC_W = idx_w(N_LLC);
  localparam int IN_W  = idx_w(N_IN);

  logic [LLC_W-1:0] req_tgt [N_IN];
  logic [IN_W-1:0]  rep_tgt [N_LLC];
  logic [N_IN-1:0]  req_gnt [N_LLC];
  logic [N_LLC-1:0] rep_gnt [N_IN];

  genvar gi;

  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_req_tgt
      assign req_tgt[gi] = in_di[gi*DATA_W + HX_LSB +: LLC_W];
    end

    // Reply index is {srcy[1], srcx[1], srcy[0]} truncated to the local count.
    for (gi = 0; gi < N_LLC; gi++) begin : g_rep_tgt
      logic [2:0] sel;
      assign sel = {llc_di_r[gi*DATA_W + SRCY_LSB + 1],
                    llc_di_r[gi*DATA_W + SRCX_LSB + 1],
                    llc_di_r[gi*DATA_W + SRCY_LSB]};
      assign rep_tgt[gi] = sel[IN_W-1:0];
    end

    for (gi = 0; gi < N_LLC; gi++) begin : g_llc_slot
      logic [N_IN-1:0]   req;
      logic              can_load;
      logic [DATA_W-1:0] mux;
      logic              valid_reg;
      logic [DATA_W-1:0] data_reg;

      always_comb begin
        req = '0;
        for (int k = 0; k < N_IN; k++) begin
          req[k] = in_si[k] && (req_tgt[k] == LLC_W'(gi));
        end
      end

      assign can_load = ~valid_reg | llc_ro[gi];

      rr_arb_n #(.N(N_IN)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .en    (can_load & ~reset),
        .gnt   (req_gnt[gi])
      );

      always_comb begin
        mux = '0;
        for (int k = 0; k < N_IN; k++) begin
          if (req_gnt[gi][k]) mux = mux | in_di[k*DATA_W +: DATA_W];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (|req_gnt[gi]) begin
          valid_reg <= 1'b1;
          data_reg  <= mux;
        end else if (llc_ro[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign llc_so[gi]                   = valid_reg;
      assign llc_do[gi*DATA_W +: DATA_W]  = data_reg;
    end

    for (gi = 0; gi < N_IN; gi++) begin : g_out_slot
      logic [N_LLC-1:0]  req;
      logic              can_load;
      logic [DATA_W-1:0] mux;
      logic              valid_reg;
      logic [DATA_W-1:0] data_reg;

      always_comb begin
        req = '0;
        for (int k = 0; k < N_LLC; k++) begin
          req[k] = llc_si_r[k] && (rep_tgt[k] == IN_W'(gi));
        end
      end

      assign can_load = ~valid_reg | out_ro[gi];

      rr_arb_n #(.N(N_LLC)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .en    (can_load & ~reset),
        .gnt   (rep_gnt[gi])
      );

      always_comb begin
        mux = '0;
        for (int k = 0; k < N_LLC; k++) begin
          if (rep_gnt[gi][k]) mux = mux | llc_di_r[k*DATA_W +: DATA_W];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (|rep_gnt[gi]) begin
          valid_reg <= 1'b1;
          data_reg  <= mux;
        end else if (out_ro[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign out_so[gi]                  = valid_reg;
      assign out_do[gi*DATA_W +: DATA_W] = data_reg;
    end
  endgenerate

  // A source targets exactly one destination, so OR-ing grants gives its accept.
  always_comb begin
    in_ri = '0;
    for (int d = 0; d < N_LLC; d++) begin
      in_ri = in_ri | req_gnt[d];
    end
  end

  always_comb begin
    llc_ri_r = '0;
    for (int d = 0; d < N_IN; d++) begin
      llc_ri_r = llc_ri_r | rep_gnt[d];
    end
  end

`ifdef CD_XBAR_STATS_EN
  generate
    for (gi = 0; gi < N_LLC; gi++) begin : g_stats
      logic [STAT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (llc_so[gi] && llc_ro[gi]) begin
          cnt_reg <= cnt_reg + STAT_W'(1);
        end
      end

      assign llc_req_cnt[gi*STAT_W +: STAT_W] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_cd_global_xbar_nxm.sv
// Bench for cd_global_xbar_nxm: vector table, hand-written corner sequences and a
// randomized run against a rank-based round-robin model. Counter checks under CD_XBAR_STATS_EN.
module tb_cd_global_xbar_nxm;

  localparam int DW = 64;
  localparam int NI = 8;
  localparam int NL = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NI-1:0]    in_si;
  logic [NI-1:0]    in_ri;
  logic [NI*DW-1:0] in_di;
  logic [NL-1:0]    llc_so;
  logic [NL-1:0]    llc_ro;
  logic [NL*DW-1:0] llc_do;
  logic [NL-1:0]    llc_si_r;
  logic [NL-1:0]    llc_ri_r;
  logic [NL*DW-1:0] llc_di_r;
  logic [NI-1:0]    out_so;
  logic [NI-1:0]    out_ro;
  logic [NI*DW-1:0] out_do;
`ifdef CD_XBAR_STATS_EN
  logic [NL*16-1:0] llc_req_cnt;
`endif

  always #5 clk = ~clk;

  cd_global_xbar_nxm #(.DATA_W(DW), .N_IN(NI), .N_LLC(NL)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_si    (in_si),
    .in_ri    (in_ri),
    .in_di    (in_di),
    .llc_so   (llc_so),
    .llc_ro   (llc_ro),
    .llc_do   (llc_do),
    .llc_si_r (llc_si_r),
    .llc_ri_r (llc_ri_r),
    .llc_di_r (llc_di_r),
    .out_so   (out_so),
    .out_ro   (out_ro),
    .out_do   (out_do)
`ifdef CD_XBAR_STATS_EN
    ,
    .llc_req_cnt (llc_req_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_req(input logic [3:0] hx, input logic [31:0] pay);
    logic [63:0] f;
    f = 64'h0;
    f[63:56] = 8'hA5;
    f[55:52] = hx;
    f[47:32] = 16'h5A5A;
    f[31:0]  = pay;
    return f;
  endfunction

  function automatic logic [63:0] mk_rep(input logic [7:0] sx, input logic [7:0] sy, input logic [31:0] pay);
    logic [63:0] f;
    f = 64'h0;
    f[63:48] = 16'hC3C3;
    f[47:40] = sx;
    f[39:32] = sy;
    f[31:0]  = pay;
    return f;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    in_si = '0; in_di = '0; llc_ro = '1;
    llc_si_r = '0; llc_di_r = '0; out_ro = '1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  si;
    logic [15:0] tg;
    logic [3:0]  ro;
    logic [7:0]  exp_ri;
    logic [3:0]  exp_so;
  } vec_t;

  vec_t vt [7];
  logic [63:0] flits [NI];

  // Reference model state: slot contents and current highest-priority source.
  logic        m_lv [NL];
  logic [63:0] m_ld [NL];
  int          m_lp [NL];
  logic        m_ov [NI];
  logic [63:0] m_od [NI];
  int          m_op [NI];

  initial begin
    vt[0] = '{si: 8'h01, tg: 16'h0002, ro: 4'hF, exp_ri: 8'h01, exp_so: 4'h4};
    vt[1] = '{si: 8'h0F, tg: 16'h00E4, ro: 4'hF, exp_ri: 8'h0F, exp_so: 4'hF};
    vt[2] = '{si: 8'h29, tg: 16'h0441, ro: 4'hF, exp_ri: 8'h01, exp_so: 4'h2};
    vt[3] = '{si: 8'hFF, tg: 16'hE4E4, ro: 4'hF, exp_ri: 8'h0F, exp_so: 4'hF};
    vt[4] = '{si: 8'hC0, tg: 16'hF000, ro: 4'hF, exp_ri: 8'h40, exp_so: 4'h8};
    vt[5] = '{si: 8'h00, tg: 16'h0000, ro: 4'hF, exp_ri: 8'h00, exp_so: 4'h0};
    vt[6] = '{si: 8'h02, tg: 16'h0000, ro: 4'h0, exp_ri: 8'h02, exp_so: 4'h1};

    // Reset behaviour with requests pending.
    reset = 1'b1;
    clear_inputs();
    in_si = 8'hFF;
    for (int k = 0; k < NI; k++) in_di[k*DW +: DW] = mk_req(4'(k), 32'(k));
    llc_si_r = 4'hF;
    @(posedge clk); #1;
    chk("reset_in_ri", in_ri, 0);
    chk("reset_llc_ri_r", llc_ri_r, 0);
    chk("reset_llc_so", llc_so, 0);
    chk("reset_out_so", out_so, 0);
    chk("reset_llc_do", llc_do, 0);
    chk("reset_out_do", out_do, 0);
    do_reset();

    // Vector table, each entry from a fresh reset.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      in_si  = vt[i].si;
      llc_ro = vt[i].ro;
      for (int k = 0; k < NI; k++) begin
        flits[k] = mk_req({2'(k), vt[i].tg[2*k +: 2]}, 32'h1000 * i + k);
        in_di[k*DW +: DW] = flits[k];
      end
      #1;
      chk($sformatf("vec%0d_in_ri", i), in_ri, vt[i].exp_ri);
      tick();
      in_si = '0;
      #1;
      chk($sformatf("vec%0d_llc_so", i), llc_so, vt[i].exp_so);
      for (int d = 0; d < NL; d++) begin
        if (vt[i].exp_so[d]) begin
          int w;
          w = -1;
          for (int k = NI - 1; k >= 0; k--)
            if (vt[i].exp_ri[k] && vt[i].tg[2*k +: 2] == 2'(d)) w = k;
          if (w >= 0) chk($sformatf("vec%0d_llc_do%0d", i, d), llc_do[d*DW +: DW], flits[w]);
        end
      end
    end

    // Round robin across inputs 0, 3, 5 all targeting LLC1.
    begin
      int order [6] = '{0, 3, 5, 0, 3, 5};
      do_reset();
      in_si = 8'h29;
      for (int c = 0; c < 6; c++) begin
        for (int k = 0; k < NI; k++) in_di[k*DW +: DW] = mk_req(4'h1, 32'(c * 256 + k));
        #1;
        chk($sformatf("rr_gnt%0d", c), in_ri, 8'(1 << order[c]));
        if (c > 0) begin
          chk($sformatf("rr_so%0d", c), llc_so, 4'h2);
          chk($sformatf("rr_do%0d", c), llc_do[1*DW +: DW], mk_req(4'h1, 32'((c - 1) * 256 + order[c - 1])));
        end
        tick();
      end
    end

    // Stall LLC1 with its slot full, then release.
    begin
      logic [63:0] f0;
      do_reset();
      f0 = mk_req(4'h1, 32'hDEAD0000);
      in_si = 8'h01;
      in_di[0 +: DW] = f0;
      tick();
      llc_ro = 4'b1101;
      in_si = 8'h29;
      for (int k = 0; k < NI; k++) if (k != 0) in_di[k*DW +: DW] = mk_req(4'h1, 32'hBEEF0000 + k);
      for (int c = 0; c < 5; c++) begin
        #1;
        chk($sformatf("stall_ri%0d", c), in_ri, 8'h00);
        chk($sformatf("stall_do%0d", c), llc_do[1*DW +: DW], f0);
        chk($sformatf("stall_so%0d", c), llc_so, 4'h2);
        tick();
      end
      llc_ro = 4'hF;
      #1;
      chk("stall_release_ri", in_ri, 8'h08);
      tick();
      in_si = '0;
      #1;
      chk("stall_release_do", llc_do[1*DW +: DW], mk_req(4'h1, 32'hBEEF0003));
    end

    // Reply path: LLC0 to local 7, then LLC2 and LLC3 contending for local 1.
    begin
      logic [63:0] rf;
      do_reset();
      rf = mk_rep(8'h02, 8'h03, 32'h0000CAFE);
      llc_si_r = 4'h1;
      llc_di_r[0 +: DW] = rf;
      #1;
      chk("rep_ri_r0", llc_ri_r, 4'h1);
      tick();
      llc_si_r = '0;
      #1;
      chk("rep_out_so", out_so, 8'h80);
      chk("rep_out_do7", out_do[7*DW +: DW], rf);
      llc_si_r = 4'hC;
      llc_di_r[2*DW +: DW] = mk_rep(8'h00, 8'h01, 32'h2);
      llc_di_r[3*DW +: DW] = mk_rep(8'h00, 8'h01, 32'h3);
      for (int c = 0; c < 4; c++) begin
        #1;
        chk($sformatf("rep_alt%0d", c), llc_ri_r, (c % 2 == 0) ? 4'h4 : 4'h8);
        tick();
      end
      llc_si_r = '0;
      #1;
      chk("rep_alt_last_do", out_do[1*DW +: DW], mk_rep(8'h00, 8'h01, 32'h3));
    end

    // Reset with every slot full.
    do_reset();
    in_si = 8'h0F;
    for (int k = 0; k < 4; k++) in_di[k*DW +: DW] = mk_req(4'(k), 32'(k));
    llc_si_r = 4'hF;
    llc_di_r[0*DW +: DW] = mk_rep(8'h00, 8'h00, 32'h10);
    llc_di_r[1*DW +: DW] = mk_rep(8'h00, 8'h01, 32'h11);
    llc_di_r[2*DW +: DW] = mk_rep(8'h02, 8'h00, 32'h12);
    llc_di_r[3*DW +: DW] = mk_rep(8'h02, 8'h01, 32'h13);
    #1;
    chk("four_in_ri", in_ri, 8'h0F);
    tick();
    llc_ro = '0;
    out_ro = '0;
    #1;
    chk("full_llc_so", llc_so, 4'hF);
    chk("full_out_so", out_so, 8'h0F);
    reset = 1'b1;
    #1;
    chk("rst_hi_in_ri", in_ri, 0);
    chk("rst_hi_llc_ri_r", llc_ri_r, 0);
    tick();
    chk("rst_mid_llc_so", llc_so, 0);
    chk("rst_mid_out_so", out_so, 0);
    reset = 1'b0;

`ifdef CD_XBAR_STATS_EN
    do_reset();
    chk("cnt_reset", llc_req_cnt, 0);
    in_si = 8'h01;
    in_di[0 +: DW] = mk_req(4'h0, 32'h1);
    repeat (3) tick();
    in_si = '0;
    tick();
    chk("cnt_three", llc_req_cnt[15:0], 16'd3);
    in_si = 8'h01;
    repeat (65532) tick();
    in_si = '0;
    tick();
    chk("cnt_ffff", llc_req_cnt[15:0], 16'hFFFF);
    in_si = 8'h01;
    tick();
    in_si = '0;
    tick();
    chk("cnt_wrap", llc_req_cnt[15:0], 16'h0000);
`endif

    // Randomized run against the reference model.
    do_reset();
    for (int d = 0; d < NL; d++) begin m_lv[d] = 0; m_ld[d] = '0; m_lp[d] = 0; end
    for (int d = 0; d < NI; d++) begin m_ov[d] = 0; m_od[d] = '0; m_op[d] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [NI-1:0]    e_ri;
      logic [NL-1:0]    e_rr;
      logic [NL*DW-1:0] e_ldo;
      logic [NI*DW-1:0] e_odo;
      logic [NL-1:0]    e_lso;
      logic [NI-1:0]    e_oso;
      in_si = 8'($urandom);
      for (int k = 0; k < NI; k++) in_di[k*DW +: DW] = {$urandom, $urandom};
      for (int d = 0; d < NL; d++) llc_ro[d] = ($urandom_range(0, 3) != 0);
      llc_si_r = 4'($urandom);
      for (int k = 0; k < NL; k++) llc_di_r[k*DW +: DW] = {$urandom, $urandom};
      for (int d = 0; d < NI; d++) out_ro[d] = ($urandom_range(0, 3) != 0);
      #1;
      e_ri = '0; e_rr = '0;
      for (int d = 0; d < NL; d++) begin
        e_lso[d] = m_lv[d];
        e_ldo[d*DW +: DW] = m_ld[d];
      end
      for (int d = 0; d < NI; d++) begin
        e_oso[d] = m_ov[d];
        e_odo[d*DW +: DW] = m_od[d];
      end
      // Winner = eligible source with the smallest distance from the priority index.
      for (int d = 0; d < NL; d++) begin
        if (!m_lv[d] || llc_ro[d]) begin
          int best, best_rank;
          best = -1; best_rank = NI;
          for (int k = 0; k < NI; k++) begin
            logic [63:0] f;
            f = in_di[k*DW +: DW];
            if (in_si[k] && int'(f[53:52]) == d && ((k - m_lp[d] + NI) % NI) < best_rank) begin
              best = k; best_rank = (k - m_lp[d] + NI) % NI;
            end
          end
          if (best >= 0) begin
            e_ri[best] = 1'b1;
            m_lv[d] = 1'b1;
            m_ld[d] = in_di[best*DW +: DW];
            m_lp[d] = (best + 1) % NI;
          end else begin
            m_lv[d] = 1'b0;
          end
        end
      end
      for (int d = 0; d < NI; d++) begin
        if (!m_ov[d] || out_ro[d]) begin
          int best, best_rank;
          best = -1; best_rank = NL;
          for (int k = 0; k < NL; k++) begin
            logic [63:0] f;
            f = llc_di_r[k*DW +: DW];
            if (llc_si_r[k] && int'({f[33], f[41], f[32]}) == d && ((k - m_op[d] + NL) % NL) < best_rank) begin
              best = k; best_rank = (k - m_op[d] + NL) % NL;
            end
          end
          if (best >= 0) begin
            e_rr[best] = 1'b1;
            m_ov[d] = 1'b1;
            m_od[d] = llc_di_r[best*DW +: DW];
            m_op[d] = (best + 1) % NL;
          end else begin
            m_ov[d] = 1'b0;
          end
        end
      end
      chk($sformatf("rnd%0d_in_ri", cyc), in_ri, e_ri);
      chk($sformatf("rnd%0d_llc_ri_r", cyc), llc_ri_r, e_rr);
      chk($sformatf("rnd%0d_llc_so", cyc), llc_so, e_lso);
      chk($sformatf("rnd%0d_llc_do", cyc), llc_do, e_ldo);
      chk($sformatf("rnd%0d_out_so", cyc), out_so, e_oso);
      chk($sformatf("rnd%0d_out_do", cyc), out_do, e_odo);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
